// File: rtl/irrigation_timer_bank_if.sv
// Control and display bundle for irrigation_timer_bank.
// The master drives the per-channel strobes, presets and rates. The slave returns status and the shared display.
interface irrigation_timer_bank_if #(
   parameter int CHANNELS = 4,
   parameter int DIGITS   = 3
);
   localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [CHANNELS-1:0]          start;
   logic [CHANNELS-1:0]          stop;
   logic [CHANNELS*DIGITS*4-1:0] preset;
   logic [CHANNELS*2-1:0]        rate;
   logic [CHANNELS-1:0]          active;
   logic [CHANNELS-1:0]          done;
   logic [CHANNELS-1:0]          err;
   logic [SELW-1:0]              sel;
   logic [DIGITS*4-1:0]          bcd_out;

   modport master (
      output start, stop, preset, rate,
      input  active, done, err, sel, bcd_out
   );

   modport slave (
      input  start, stop, preset, rate,
      output active, done, err, sel, bcd_out
   );
endinterface

// File: rtl/irrigation_timer_bank.sv
// Bank of BCD countdown channels with per-channel tick dividers and a registered lowest-active display mux.
// Status updates on the sampling edge and the display follows one edge later. There is no backpressure. IRRIGATION_TIMER_AUTO_RELOAD_EN makes expiry periodic.
module irrigation_timer_bank #(
   parameter int CHANNELS   = 4,
   parameter int DIGITS     = 3,
   parameter int DIV_FAST   = 2,
   parameter int DIV_NORMAL = 4,
   parameter int DIV_SLOW   = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   irrigation_timer_bank_if.slave bus
);
   localparam int CW   = DIGITS * 4;
   localparam int PW   = $clog2(DIV_SLOW) + 1;
   localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   logic [CW-1:0]       cnt_w [CHANNELS];
   logic [CHANNELS-1:0] act_w;
   logic [SELW-1:0]     sel_nx;
   logic [SELW-1:0]     sel_q;
   logic [CW-1:0]       bcd_q;

   function automatic logic bcd_valid(input logic [CW-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int d = 0; d < DIGITS; d++)
         if (v[d*4 +: 4] > 4'd9) ok = 1'b0;
      return ok;
   endfunction

   function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      logic          borrow;
      r      = v;
      borrow = 1'b1;
      for (int d = 0; d < DIGITS; d++) begin
         if (borrow) begin
            if (v[d*4 +: 4] == 4'd0) begin
               r[d*4 +: 4] = 4'd9;
            end else begin
               r[d*4 +: 4] = v[d*4 +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [PW-1:0] tick_limit(input logic [1:0] r);
      logic [PW-1:0] lim;
      case (r)
         2'b01:   lim = PW'(DIV_FAST - 1);
         2'b10:   lim = PW'(DIV_SLOW - 1);
         default: lim = PW'(DIV_NORMAL - 1);
      endcase
      return lim;
   endfunction

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic          start_i, stop_i;
      logic [CW-1:0] pre_i;
      logic [1:0]    rate_i;
      state_t        state_r;
      logic [CW-1:0] cnt_r;
      logic [PW-1:0] presc_r;
      logic          act_r, done_r, err_r;
`ifdef IRRIGATION_TIMER_AUTO_RELOAD_EN
      logic [CW-1:0] reload_r;
`endif

      assign start_i = bus.start[g];
      assign stop_i  = bus.stop[g];
      assign pre_i   = bus.preset[g*CW +: CW];
      assign rate_i  = bus.rate[g*2 +: 2];

      // Priority: stop, then a valid start, then normal progress (an invalid start only flags err).
      always_ff @(posedge clk) begin
         if (!reset_n) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            presc_r  <= '0;
            act_r    <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
`ifdef IRRIGATION_TIMER_AUTO_RELOAD_EN
            reload_r <= '0;
`endif
         end else begin
            done_r <= 1'b0;
            if (stop_i) begin
               state_r <= IDLE;
               act_r   <= 1'b0;
            end else if (start_i && bcd_valid(pre_i)) begin
               err_r   <= 1'b0;
               presc_r <= '0;
               if (pre_i == '0) begin
                  state_r <= IDLE;
                  cnt_r   <= '0;
                  act_r   <= 1'b0;
                  done_r  <= 1'b1;
               end else begin
                  state_r  <= RUN;
                  cnt_r    <= pre_i;
                  act_r    <= 1'b1;
`ifdef IRRIGATION_TIMER_AUTO_RELOAD_EN
                  reload_r <= pre_i;
`endif
               end
            end else begin
               if (start_i) err_r <= 1'b1;
               if (state_r != IDLE) begin
                  if (rate_i == 2'b11) begin
                     state_r <= HOLD;
                  end else begin
                     state_r <= RUN;
                     if (presc_r >= tick_limit(rate_i)) begin
                        presc_r <= '0;
                        if (cnt_r == '0) begin
                           done_r <= 1'b1;
`ifdef IRRIGATION_TIMER_AUTO_RELOAD_EN
                           cnt_r   <= reload_r;
`else
                           state_r <= IDLE;
                           act_r   <= 1'b0;
`endif
                        end else begin
                           cnt_r <= bcd_dec(cnt_r);
                        end
                     end else begin
                        presc_r <= presc_r + PW'(1);
                     end
                  end
               end
            end
         end
      end

      assign cnt_w[g]      = cnt_r;
      assign act_w[g]      = act_r;
      assign bus.active[g] = act_r;
      assign bus.done[g]   = done_r;
      assign bus.err[g]    = err_r;
   end

   always_comb begin
      sel_nx = '0;
      for (int i = CHANNELS - 1; i >= 0; i--)
         if (act_w[i]) sel_nx = SELW'(i);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sel_q <= '0;
         bcd_q <= '0;
      end else begin
         sel_q <= sel_nx;
         bcd_q <= cnt_w[sel_nx];
      end
   end

   assign bus.sel     = sel_q;
   assign bus.bcd_out = bcd_q;
endmodule

// File: doc/irrigation_timer_bank.md
# irrigation_timer_bank

Parametrised multi-channel BCD countdown bank for the irrigation controller. Each channel is one timed activity, such as drip, sprinkler, filling or cleaning. A channel has its own preset, rate and run state. All channels run on the single system clock and use per-channel tick dividers instead of separate clocks. A registered priority selector drives one channel's BCD count onto the shared display bus.

## Interface
Parameters:
- CHANNELS, 4: number of independent timer channels (1–8)
- DIGITS, 3: BCD digits per channel (1–4)
- DIV_FAST, 2: clk cycles per count tick at fast rate (≥1)
- DIV_NORMAL, 4: clk cycles per tick at normal rate (≥1)
- DIV_SLOW, 8: clk cycles per tick at slow rate (≥1)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  CHANNELS  per-channel start strobe; loads the preset and runs
- stop  in  CHANNELS  per-channel abort strobe
- preset  in  CHANNELS·DIGITS·4  BCD preset; channel i occupies bits [i·DIGITS·4 +: DIGITS·4], digit 0 is the LSD
- rate  in  CHANNELS·2  per channel: 00 normal, 01 fast, 10 slow, 11 hold
- active  out  CHANNELS  channel is running or held
- done  out  CHANNELS  one-cycle expiry pulse
- err  out  CHANNELS  sticky: the last start had an invalid BCD preset
- sel  out  max(1,clog2(CHANNELS))  channel currently shown on bcd_out
- bcd_out  out  DIGITS·4  BCD count of channel sel

## Operation
- Per-channel FSM states: IDLE, RUN, HOLD.
  - IDLE → RUN on start with a valid, nonzero preset.
  - RUN ↔ HOLD follows rate==11 versus rate!=11.
  - RUN/HOLD → IDLE on stop, or on expiry when AUTO_RELOAD_EN is not defined.
- Each channel has a prescaler (width clog2(DIV_SLOW)+1) and a DIGITS-digit BCD count.
- In RUN, the prescaler increments every cycle. When it reaches D−1 for the current rate, it clears and issues a tick.
- On a tick with count ≠ 0: BCD decrement with borrow; a digit wraps 0→9 and borrows from the next digit.
- On a tick with count == 0: expiry. done pulses, and the channel returns to IDLE with count = 0.
- HOLD freezes both the prescaler and the count; active stays 1.
- A rate change mid-run applies the new D immediately. If prescaler ≥ new D−1, the tick fires on the next edge.
- Start validity:
  - Any preset digit > 9 rejects the start. err[i] is set, the state is unchanged and no done is issued.
  - A valid start clears err[i].
  - A valid all-zero preset does not enter RUN. done pulses on the next edge instead.
- Start while RUN/HOLD restarts the channel: the preset is reloaded and the prescaler cleared.
- start and stop on the same channel in the same cycle: stop wins.
- An expiry tick coinciding with start: the start wins and no done is issued.
- Display: sel = lowest-index channel with active=1. If none is active, sel = 0. bcd_out = count[sel]. Both are registered.

## Timing
- Reset values (reset_n low at an edge): all FSMs IDLE, counts 0, prescalers 0, active/done/err = 0, sel = 0, bcd_out = 0. Reset overrides every other input, including mid-run.
- Sample start at edge k, preset value P (decimal), divisor D, no hold, no rate change:
  - active = 1 and count = P after edge k.
  - Decrements at edges k+D, k+2D, …, k+P·D.
  - Expiry at edge k+(P+1)·D: done = 1 for exactly the following cycle, and active = 0.
- HOLD cycles extend the timeline one-for-one.
- bcd_out and sel lag the internal count and active by one edge.
- stop at edge k: active = 0 after edge k; no done.

## Configuration
- IRRIGATION_TIMER_AUTO_RELOAD_EN
  - Defined: on expiry the channel pulses done, reloads the preset latched at its last valid start, clears the prescaler and stays in RUN. A periodic channel ends only on stop or reset. The reload of a zero preset cannot occur, because zero never enters RUN.
  - Not defined: expiry returns the channel to IDLE, as described above.

## Test plan
- Normal run, default parameters: ch0 preset 002, rate 00, start at edge 0. Required: bcd_out 002→001→000 (one edge late), done[0] high in the single cycle after edge 12, active[0] falls there, err = 0.
- Hold and rate change: ch1 preset 001 fast, hold for 5 cycles after edge 1, then switch to slow. Required: count frozen while held, active stays 1, remaining ticks use D = 8, and done occurs at the computed edge.
- Invalid and zero presets: ch2 start with preset 0A3. Required: err[2] = 1, active[2] = 0. Then start with preset 000. Required: err[2] = 0, one-cycle done[2], active[2] never rises.
- Priority and collisions: ch3 and ch1 running, start and stop on ch1 in the same cycle. Required: ch1 goes idle and sel switches from 1 to 3 one edge later. Restart ch3 mid-run. Required: its count reloads to the preset with no done.
- Reset mid-operation: reset_n low for one edge while three channels run. Required: all outputs zero on the following cycle, and no done pulses.
- With IRRIGATION_TIMER_AUTO_RELOAD_EN: ch0 preset 001 normal. Required: done[0] pulses at edges 8, 16 and 24, active[0] stays 1, and stop ends the run without a done.
